// File: rtl/mux_bus_master.sv
// mux_bus_master: drives an external device over a multiplexed address/data
// bus. Sequence per transfer: IDLE -> ADDR (latch pulse) -> HOLD -> STROBE
// (N+1 cycles, plus external waits when enabled) -> END (ack) -> IDLE.
// A one-cycle bus recovery follows END before the next request is taken.
//
// Optional feature macro: WAIT_EXT_EN
//   defined   : STROBE is extended while ext_wait=1 once the count reaches 0.
//   undefined : ext_wait is ignored and STROBE is exactly N+1 cycles.
//
// Handshake: req is sampled only in IDLE (and not in the recovery cycle);
// the request is consumed on that edge, and ack pulses for exactly one cycle
// in END. busy is high from ADDR through END.
module mux_bus_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int WAIT_W = 4
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WAIT_W-1:0] wait_cycles,
  input  logic              ext_wait,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] bus_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic              bus_dir,
  output logic              latch_enable,
  output logic              OEb,
  output logic              WEb,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_STROBE = 3'd3,
    ST_END    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                recov_q;

  logic                accept;
  logic                strobe_done;
  logic                capture;
  logic [DATA_W-1:0]   addr_bus;

  logic                ack_c;
  logic                le_c;
  logic                oeb_c;
  logic                web_c;
  logic                dir_c;
  logic [DATA_W-1:0]   bus_c;

  // Address is zero-extended onto the wider bus.
  assign addr_bus = DATA_W'(addr_q);

  assign accept  = (state_q == ST_IDLE) && req && !recov_q;
`ifdef WAIT_EXT_EN
  // Strobe may only finish once the count is exhausted and the device is ready.
  assign strobe_done = (cnt_q == '0) && !ext_wait;
`else
  logic unused_ext_wait;
  assign unused_ext_wait = ext_wait;
  assign strobe_done = (cnt_q == '0);
`endif
  // Read data is taken on the last STROBE edge, while OEb is still low.
  assign capture = (state_q == ST_STROBE) && strobe_done && !we_q;

  // State register and wait counter.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      recov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      recov_q <= (state_q == ST_END);
    end
  end

  // Transfer parameters captured at acceptance; read data captured at strobe end.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (capture) begin
        rdata_q <= bus_in;
      end
    end
  end

  // Next-state, counter and bus-pin decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_c   = 1'b0;
    le_c    = 1'b0;
    oeb_c   = 1'b1;
    web_c   = 1'b1;
    dir_c   = 1'b1;
    bus_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADDR;
          cnt_d   = wait_cycles;
        end
      end
      ST_ADDR: begin
        le_c    = 1'b1;
        dir_c   = 1'b0;
        bus_c   = addr_bus;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        dir_c   = 1'b0;
        bus_c   = addr_bus;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (we_q) begin
          dir_c = 1'b0;
          bus_c = wdata_q;
          web_c = 1'b0;
        end else begin
          dir_c = 1'b1;
          bus_c = addr_bus;
          oeb_c = 1'b0;
        end
        if (strobe_done) begin
          state_d = ST_END;
        end else if (cnt_q != '0) begin
          // Saturating count: waits on ext_wait hold the counter at zero.
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_END: begin
        ack_c = 1'b1;
        // Write keeps data driven so the WEb rising edge sees it stable;
        // read keeps the pads released as the turnaround cycle.
        if (we_q) begin
          dir_c = 1'b0;
          bus_c = wdata_q;
        end else begin
          dir_c = 1'b1;
          bus_c = addr_bus;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack          = ack_c;
  assign latch_enable = le_c;
  assign OEb          = oeb_c;
  assign WEb          = web_c;
  assign bus_dir      = dir_c;
  assign bus_out      = bus_c;
  assign rdata        = rdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mux_bus_master.sv
// Testbench for mux_bus_master: directed transfers with hand-computed timing,
// then randomized traffic, all cross-checked every cycle against a timeline
// model of the bus protocol and a simple external memory device.
module tb_mux_bus_master;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int WW = 4;
`ifdef WAIT_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [WW-1:0] wait_cycles = '0;
  logic          ext_wait = 1'b0;
  logic [DW-1:0] bus_in;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [DW-1:0] bus_out;
  logic          bus_dir;
  logic          latch_enable;
  logic          OEb;
  logic          WEb;
  logic [2:0]    dbg_state_unused;

  mux_bus_master #(.DATA_W(DW), .ADDR_W(AW), .WAIT_W(WW)) dut (
    .wb_clk_i     (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .wait_cycles  (wait_cycles),
    .ext_wait     (ext_wait),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .bus_out      (bus_out),
    .bus_in       (bus_in),
    .bus_dir      (bus_dir),
    .latch_enable (latch_enable),
    .OEb          (OEb),
    .WEb          (WEb),
    .dbg_state_o  (dbg_state_unused)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external device ----------------
  logic [DW-1:0] dev_mem [16];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] lat_addr = '0;
  logic [DW-1:0] junk = '0;
  bit            dev_en = 1'b0;

  always @(negedge latch_enable) lat_addr = bus_out;
  always @(posedge WEb) if (dev_en && rst_n) dev_mem[lat_addr[3:0]] = bus_out;
  always @* bus_in = (OEb === 1'b0) ? dev_mem[lat_addr[3:0]] : junk;

  // ---------------- reference model ----------------
  // Timeline of the current transfer: m_k counts cycles since acceptance
  // (1 = address phase), m_end is the cycle number of the ack once known.
  bit            m_active = 1'b0;
  bit            m_recover = 1'b0;
  int            m_k = 0;
  int            m_end = 0;
  int            m_n = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(negedge rst_n) begin
    m_active  = 1'b0;
    m_recover = 1'b0;
    m_rdata   = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_active) begin
        if (m_end != 0 && m_k == m_end) begin
          m_active  = 1'b0;
          m_recover = 1'b1;
        end else begin
          if (m_end == 0 && m_k >= 3 + m_n && !(EXT && ext_wait)) begin
            m_end = m_k + 1;
            if (m_we) model_mem[m_addr[3:0]] = m_wdata;
            else      m_rdata = model_mem[m_addr[3:0]];
          end
          m_k++;
        end
      end else if (m_recover) begin
        m_recover = 1'b0;
      end else if (req) begin
        m_active = 1'b1;
        m_k      = 1;
        m_end    = 0;
        m_n      = int'(wait_cycles);
        m_we     = we;
        m_addr   = addr;
        m_wdata  = wdata;
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    logic          e_ack, e_le, e_oeb, e_web, e_dir, strobe, aphase, chk_bus;
    logic [DW-1:0] e_bus;
    strobe  = m_active && m_k >= 3 && (m_end == 0 || m_k < m_end);
    aphase  = m_active && (m_k == 1 || m_k == 2);
    e_ack   = m_active && m_end != 0 && m_k == m_end;
    e_le    = m_active && m_k == 1;
    e_oeb   = !(strobe && !m_we);
    e_web   = !(strobe && m_we);
    chk_bus = 1'b1;
    if (!m_active)   begin e_dir = 1'b1; e_bus = '0; end
    else if (aphase) begin e_dir = 1'b0; e_bus = m_addr; end
    else if (m_we)   begin e_dir = 1'b0; e_bus = m_wdata; end
    else begin
      e_dir = 1'b1;
      e_bus = m_addr;
      chk_bus = strobe;
    end
    check("cmp_busy", busy, m_active);
    check("cmp_ack", ack, e_ack);
    check("cmp_latch_enable", latch_enable, e_le);
    check("cmp_OEb", OEb, e_oeb);
    check("cmp_WEb", WEb, e_web);
    check("cmp_bus_dir", bus_dir, e_dir);
    check("cmp_rdata", rdata, m_rdata);
    if (chk_bus) check("cmp_bus_out", bus_out, e_bus);
    if (e_ack && m_we) check("cmp_dev_mem", dev_mem[m_addr[3:0]], model_mem[m_addr[3:0]]);
  end

  // ---------------- driver tasks ----------------
  logic          log_ack [64];
  logic          log_oe  [64];
  logic          log_we  [64];
  logic          log_dir [64];
  logic          log_le  [64];
  logic [DW-1:0] log_bus [64];
  logic [DW-1:0] log_rd  [64];

  // Issue one request in cycle 0 and record pins for cycles 0..cycles-1.
  task automatic run(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int n, input int ext_from, input int ext_len,
                     input bit hold, input int cycles);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; wait_cycles = WW'(n); ext_wait = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      log_ack[c] = ack; log_oe[c] = OEb; log_we[c] = WEb;
      log_dir[c] = bus_dir; log_le[c] = latch_enable;
      log_bus[c] = bus_out; log_rd[c] = rdata;
      @(posedge clk); #1;
      if (!hold) begin
        req = 1'($urandom_range(0, 1)); we = 1'($urandom);
        addr = AW'($urandom); wdata = DW'($urandom); wait_cycles = WW'($urandom);
      end
      ext_wait = (c + 1 >= ext_from) && (c + 1 < ext_from + ext_len);
    end
    req = 1'b0; ext_wait = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int first_ack(input int cycles);
    for (int c = 0; c < cycles; c++) if (log_ack[c]) return c;
    return -1;
  endfunction

  function automatic int count_low(input int which, input int cycles);
    int cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      if (which == 0 && !log_oe[c]) cnt++;
      if (which == 1 && !log_we[c]) cnt++;
    end
    return cnt;
  endfunction

  function automatic int count_ack(input int cycles);
    int cnt = 0;
    for (int c = 0; c < cycles; c++) if (log_ack[c]) cnt++;
    return cnt;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int acks;
    for (int i = 0; i < 16; i++) begin
      dev_mem[i]   = DW'($urandom);
      model_mem[i] = dev_mem[i];
    end
    dev_mem[2]   = 16'h0EB8;
    model_mem[2] = 16'h0EB8;
    idle(3);
    check("reset_busy", busy, 1'b0);
    check("reset_OEb", OEb, 1'b1);
    check("reset_WEb", WEb, 1'b1);
    check("reset_bus_dir", bus_dir, 1'b1);
    check("reset_bus_out", bus_out, 16'h0000);
    check("reset_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    dev_en = 1'b1;
    idle(3);

    // Write FE00 <- 0041, N=0
    run(1'b1, 16'hFE00, 16'h0041, 0, 99, 0, 1'b0, 5);
    check("wr_le_c1", log_le[1], 1'b1);
    check("wr_bus_c1", log_bus[1], 16'hFE00);
    check("wr_web_c2", log_we[2], 1'b1);
    check("wr_web_c3", log_we[3], 1'b0);
    check("wr_web_c4", log_we[4], 1'b1);
    check("wr_bus_c3", log_bus[3], 16'h0041);
    check("wr_bus_c4", log_bus[4], 16'h0041);
    check("wr_ack_cycle", first_ack(5), 4);
    check("wr_dev_mem", dev_mem[0], 16'h0041);
    check("wr_model_mem", model_mem[0], 16'h0041);
    idle(3);

    // Read 0002 -> 0EB8, N=2
    run(1'b0, 16'h0002, 16'h0000, 2, 99, 0, 1'b0, 7);
    check("rd_oe_low_count", count_low(0, 7), 3);
    check("rd_oe_c3", log_oe[3], 1'b0);
    check("rd_oe_c5", log_oe[5], 1'b0);
    check("rd_oe_c6", log_oe[6], 1'b1);
    check("rd_dir_c2", log_dir[2], 1'b0);
    check("rd_dir_c3", log_dir[3], 1'b1);
    check("rd_dir_c6", log_dir[6], 1'b1);
    check("rd_ack_cycle", first_ack(7), 6);
    check("rd_rdata", log_rd[6], 16'h0EB8);
    idle(3);

    // req held high, N=0: acks at 4 and 10 only
    run(1'b1, 16'h0003, 16'h1234, 0, 99, 0, 1'b1, 11);
    check("hold_ack_c4", log_ack[4], 1'b1);
    check("hold_ack_c10", log_ack[10], 1'b1);
    check("hold_ack_count", count_ack(11), 2);
    idle(3);

    // N=15 write: 16 strobe cycles, ack in cycle 19
    run(1'b1, 16'h0007, 16'hA5A5, 15, 99, 0, 1'b0, 20);
    check("n15_web_low_count", count_low(1, 20), 16);
    check("n15_ack_cycle", first_ack(20), 19);
    idle(3);

    // External wait: read N=1, ext_wait high for cycles 3..5
    if (EXT) begin
      run(1'b0, 16'h0002, 16'h0000, 1, 3, 3, 1'b0, 8);
      check("ext_ack_cycle", first_ack(8), 7);
      check("ext_oe_low_count", count_low(0, 8), 4);
    end else begin
      run(1'b0, 16'h0002, 16'h0000, 1, 3, 3, 1'b0, 6);
      check("ext_ack_cycle", first_ack(6), 5);
      check("ext_oe_low_count", count_low(0, 6), 2);
    end
    idle(3);

    // Reset asserted in cycle 3 of a write with N=3
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 16'hBEEF; wait_cycles = 4'd3;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_web_before", WEb, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_web_after", WEb, 1'b1);
    check("abort_busy_after", busy, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    idle(2);
    run(1'b0, 16'h0002, 16'h0000, 0, 99, 0, 1'b0, 5);
    check("post_abort_ack_cycle", first_ack(5), 4);
    check("post_abort_rdata", log_rd[4], 16'h0EB8);
    idle(3);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      req         = ($urandom_range(0, 3) == 0);
      we          = 1'($urandom);
      addr        = AW'($urandom);
      wdata       = DW'($urandom);
      wait_cycles = ($urandom_range(0, 9) == 0) ? 4'd15 : WW'($urandom_range(0, 3));
      ext_wait    = ($urandom_range(0, 3) == 0);
      junk        = DW'($urandom);
      rst_n       = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0; ext_wait = 1'b0;
    idle(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
